// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the memory-stage load/store unit.
//   lsu_state_e  access FSM states
//   F3_*         RV32 funct3 encodings for byte/half/word accesses
//   sb_entry_t   one posted store: word address, byte-lane mask, lane-shifted data
//   is_misaligned / store_mask / load_extract: lane and size helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_entry_t;

  // Unknown funct3 values fall through to word behaviour.
  function automatic logic is_misaligned(logic we, logic [2:0] f3, logic [1:0] lane);
    logic res;
    if (f3 == F3_B || (!we && f3 == F3_BU)) begin
      res = 1'b0;
    end else if (f3 == F3_H || (!we && f3 == F3_HU)) begin
      res = lane[0];
    end else begin
      res = (lane != 2'b00);
    end
    return res;
  endfunction

  function automatic logic [3:0] store_mask(logic [2:0] f3, logic [1:0] lane);
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << lane;
      F3_H:    m = 4'b0011 << lane;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(logic [2:0] f3, logic [1:0] lane,
                                               logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {lane, 3'b000};
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'h0, s[7:0]};
      F3_HU:   r = {16'h0, s[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_sb_fifo.sv
// lsu_sb_fifo: posted-store FIFO with a parallel word-address compare port.
//   i_push/i_push_entry  enqueue (caller guarantees !o_full)
//   i_pop                dequeue head (caller guarantees count != 0)
//   i_cmp_addr/o_hit     hit when any valid entry holds i_cmp_addr
//   o_head, o_full, o_count  head entry and occupancy
module lsu_sb_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_push,
  input  sb_entry_t       i_push_entry,
  input  logic            i_pop,
  input  logic [31:0]     i_cmp_addr,
  output sb_entry_t       o_head,
  output logic            o_full,
  output logic [CntW-1:0] o_count,
  output logic            o_hit
);

  localparam int unsigned PtrW = $clog2(Depth);

  sb_entry_t        r_mem [Depth];
  logic [Depth-1:0] r_valid;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic [Depth-1:0] w_hit_vec;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: r_valid gates every use.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  for (genvar g = 0; g < Depth; g++) begin : g_cmp
    assign w_hit_vec[g] = r_valid[g] && (r_mem[g].addr == i_cmp_addr);
  end

  assign o_hit   = |w_hit_vec;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CntW'(Depth));
  assign o_count = r_count;

endmodule

// File: rtl/lsu_store_buffer_unit.sv
// lsu_store_buffer_unit: memory-stage load/store unit with posted-store buffer.
//   i_req_*          memory-stage request (held stable while o_lsu_stall=1)
//   o_load_data/o_load_valid  registered load result and one-cycle valid pulse
//   o_lsu_stall      hold the memory stage
//   o_misalign       misaligned access pulse (no memory op)
//   o_sb_empty       no buffered or in-flight store
//   o_cs/o_mem_rd_wr/o_mask/o_mem_addr/o_mem_write_data  registered memory request
//   i_mem_read_data/i_mem_valid  memory response
module lsu_store_buffer_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned CNT_W    = $clog2(SB_DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_func3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_load_valid,
  output logic            o_lsu_stall,
  output logic            o_misalign,
  output logic            o_sb_empty,
  output logic            o_cs,
  output logic            o_mem_rd_wr,
  output logic [3:0]      o_mask,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_write_data,
  input  logic [XLEN-1:0] i_mem_read_data,
  input  logic            i_mem_valid
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("lsu_store_buffer_unit: only XLEN=32 is supported");
  end
  if (SB_DEPTH < 2 || (SB_DEPTH & (SB_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("lsu_store_buffer_unit: SB_DEPTH must be a power of two >= 2");
  end

  lsu_state_e      r_state;
  lsu_state_e      w_state_next;
  logic            r_cs;
  logic            r_mem_rd_wr;
  logic [3:0]      r_mask;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_write_data;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_valid;
  logic [2:0]      r_ld_func3;
  logic [1:0]      r_ld_lane;

  logic            w_req_live;
  logic            w_mis;
  logic            w_store_req;
  logic            w_load_req;
  logic [XLEN-1:0] w_word_addr;
  logic [1:0]      w_lane;
  logic            w_fifo_hit;
  logic            w_raw_hit;
  logic            w_full;
  logic [CNT_W-1:0] w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_load_go;
  logic            w_done;
  sb_entry_t       w_push_entry;
  sb_entry_t       w_head;

  // In the load_valid cycle the stage still shows the finished load; it is consumed, not reissued.
  assign w_req_live  = i_req_valid & ~r_load_valid;
  assign w_word_addr = {i_req_addr[XLEN-1:2], 2'b00};
  assign w_lane      = i_req_addr[1:0];
  assign w_mis       = is_misaligned(i_req_we, i_req_func3, w_lane);
  assign w_store_req = w_req_live & i_req_we & ~w_mis;
  assign w_load_req  = w_req_live & ~i_req_we & ~w_mis;

  assign w_raw_hit = w_fifo_hit | ((r_state == STORE_WAIT) && (r_mem_addr == w_word_addr));
  assign w_push    = w_store_req & ~w_full;
  // A pending non-conflicting load wins over draining.
  assign w_load_go = (r_state == IDLE) & w_load_req & ~w_raw_hit;
  assign w_pop     = (r_state == IDLE) & (w_count != '0) & ~w_load_go;
  assign w_done    = i_mem_valid & (r_state != IDLE);

  always_comb begin
    w_push_entry.addr = w_word_addr;
    w_push_entry.mask = store_mask(i_req_func3, w_lane);
    w_push_entry.data = i_req_wdata << {w_lane, 3'b000};
  end

  lsu_sb_fifo #(
    .Depth (SB_DEPTH),
    .CntW  (CNT_W)
  ) u_sb_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_cmp_addr   (w_word_addr),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_count      (w_count),
    .o_hit        (w_fifo_hit)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load_go) begin
          w_state_next = LOAD_WAIT;
        end else if (w_pop) begin
          w_state_next = STORE_WAIT;
        end
      end
      LOAD_WAIT, STORE_WAIT: begin
        if (i_mem_valid) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_lsu_stall = w_load_req | (w_store_req & w_full);
    o_misalign  = w_req_live & w_mis;
    o_sb_empty  = (w_count == '0) && (r_state != STORE_WAIT);
  end

  // Memory request registers hold until the access completes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cs             <= 1'b0;
      r_mem_rd_wr      <= 1'b0;
      r_mask           <= '0;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
      r_load_data      <= '0;
      r_load_valid     <= 1'b0;
      r_ld_func3       <= '0;
      r_ld_lane        <= '0;
    end else begin
      r_load_valid <= 1'b0;
      if (w_load_go) begin
        r_cs        <= 1'b1;
        r_mem_rd_wr <= 1'b1;
        r_mask      <= 4'hF;
        r_mem_addr  <= w_word_addr;
        r_ld_func3  <= i_req_func3;
        r_ld_lane   <= w_lane;
      end else if (w_pop) begin
        r_cs             <= 1'b1;
        r_mem_rd_wr      <= 1'b0;
        r_mask           <= w_head.mask;
        r_mem_addr       <= w_head.addr;
        r_mem_write_data <= w_head.data;
      end else if (w_done) begin
        r_cs <= 1'b0;
        if (r_state == LOAD_WAIT) begin
          r_load_valid <= 1'b1;
          r_load_data  <= load_extract(r_ld_func3, r_ld_lane, i_mem_read_data);
        end
      end
    end
  end

  assign o_cs             = r_cs;
  assign o_mem_rd_wr      = r_mem_rd_wr;
  assign o_mask           = r_mask;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_write_data = r_mem_write_data;
  assign o_load_data      = r_load_data;
  assign o_load_valid     = r_load_valid;

endmodule

// File: tb/tb_lsu_store_buffer_unit.sv
// Bench: drives the LSU as the pipeline would, answers memory with a latency model and checks
// against an architectural memory image updated in program order.
module tb_lsu_store_buffer_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic        load_valid, lsu_stall, misalign, sb_empty, cs, mem_rd_wr, mem_valid;
  logic [3:0]  mask;

  always #5 clk = ~clk;

  lsu_store_buffer_unit #(.XLEN(32), .SB_DEPTH(4)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_req_valid      (req_valid),
    .i_req_we         (req_we),
    .i_req_func3      (req_f3),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_load_data      (load_data),
    .o_load_valid     (load_valid),
    .o_lsu_stall      (lsu_stall),
    .o_misalign       (misalign),
    .o_sb_empty       (sb_empty),
    .o_cs             (cs),
    .o_mem_rd_wr      (mem_rd_wr),
    .o_mask           (mask),
    .o_mem_addr       (mem_addr),
    .o_mem_write_data (mem_wdata),
    .i_mem_read_data  (mem_rdata),
    .i_mem_valid      (mem_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] arch_mem  [16];
  logic [31:0] slave_mem [16];
  wr_t         exp_wr_q [$];
  logic [31:0] cur_ld_word = '0;
  int          lat_fixed = 0;
  bit          spur_en = 0;
  bit          busy = 0;
  int          wait_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic we, input logic [2:0] f3);
    if (f3 == 3'b000 || (!we && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!we && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int          size, off;
    logic [63:0] v, lim;
    size = acc_size(1'b0, f3);
    off  = int'(addr % 4);
    lim  = (64'd1 << (8 * size)) - 64'd1;
    v    = ({32'h0, arch_mem[addr[5:2]]} >> (8 * off)) & lim;
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*size-1]) v = v | ~lim;
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int  size, off;
    wr_t e;
    size   = acc_size(1'b1, f3);
    off    = int'(addr % 4);
    e.addr = addr & ~32'h3;
    e.mask = 4'(((1 << size) - 1) << off);
    e.data = wd << (8 * off);
    for (int b = 0; b < 4; b++)
      if (e.mask[b]) arch_mem[addr[5:2]][8*b +: 8] = e.data[8*b +: 8];
    exp_wr_q.push_back(e);
  endtask

  // Memory slave: accepts cs, answers after a latency, applies writes by lane.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (reset) begin
        busy = 0;
      end else if (cs) begin
        if (!busy) begin
          busy = 1;
          wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        end
        if (wait_cnt == 0) begin
          busy = 0;
          mem_valid = 1'b1;
          if (mem_rd_wr) begin
            check_eq("rd_addr", mem_addr, cur_ld_word);
            check_eq("rd_mask", 32'(mask), 32'hF);
            mem_rdata = slave_mem[mem_addr[5:2]];
          end else if (exp_wr_q.size() == 0) begin
            check_eq("wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
          end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            check_eq("wr_addr", mem_addr, e.addr);
            check_eq("wr_mask", 32'(mask), 32'(e.mask));
            check_eq("wr_data", mem_wdata, e.data);
            for (int b = 0; b < 4; b++)
              if (mask[b]) slave_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end else begin
          wait_cnt--;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        mem_valid = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int stalls, output logic [31:0] ld);
    logic exp_mis;
    bit   done;
    exp_mis = (addr % acc_size(we, f3)) != 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    if (!we) cur_ld_word = addr & ~32'h3;
    stalls = 0; done = 0; ld = '0;
    while (!done) begin
      #1;
      if (!lsu_stall) begin
        done = 1;
        check_eq("misalign", 32'(misalign), 32'(exp_mis));
        if (exp_mis) begin
          check_eq("mis_ld_valid", 32'(load_valid), 32'd0);
        end else if (we) begin
          model_store(f3, addr, wd);
        end else begin
          check_eq("ld_valid", 32'(load_valid), 32'd1);
          check_eq("ld_data", load_data, model_load(f3, addr));
          ld = load_data;
        end
      end else begin
        stalls++;
        if (stalls > 200) begin
          check_eq("stall_timeout", 32'(stalls), 32'd0);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(input string tag);
    int n = 0;
    #1;
    while (!(sb_empty && !busy && !cs) && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    check_eq(tag, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    int          st;
    int          st_arr [6];
    logic [31:0] ld;
    logic [31:0] a;
    int          n;

    req_valid = 0; req_we = 0; req_f3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      arch_mem[i] = $urandom;
      slave_mem[i] = arch_mem[i];
    end
    arch_mem[0] = 32'hDEADBEEF; slave_mem[0] = 32'hDEADBEEF;
    arch_mem[1] = 32'h8001_0000; slave_mem[1] = 32'h8001_0000;

    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_cs", 32'(cs), 32'd0);
    check_eq("rst_sb_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_load_valid", 32'(load_valid), 32'd0);
    check_eq("rst_mask_rdwr", {27'h0, mask, mem_rd_wr}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    reset = 1'b0;

    // Spec load examples (memory answers in the cs cycle).
    lat_fixed = 0;
    issue(1'b0, 3'b010, 32'h100, 32'h0, st, ld);
    check_eq("lw_stall_cycles", 32'(st), 32'd2);
    check_eq("lw_data", ld, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 32'h107, 32'h0, st, ld);
    check_eq("lb_sext", ld, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h107, 32'h0, st, ld);
    check_eq("lbu_zext", ld, 32'h00000080);
    issue(1'b0, 3'b001, 32'h106, 32'h0, st, ld);
    check_eq("lh_sext", ld, 32'hFFFF8001);

    // Byte store: no stall, then lane-shifted write.
    issue(1'b1, 3'b000, 32'h109, 32'hAB, st, ld);
    check_eq("sb_no_stall", 32'(st), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(cs && !mem_rd_wr) && n < 10);
    check_eq("sb_mask", 32'(mask), 32'h2);
    check_eq("sb_wdata", mem_wdata, 32'h0000AB00);
    check_eq("sb_addr", mem_addr, 32'h108);
    wait_sb_empty("sb_drained");

    // Slow memory fills the buffer: the sixth back-to-back store must stall.
    lat_fixed = 20;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 3'b010, 32'h110 + 32'(4 * i), 32'h1000 + 32'(i), st, ld);
      st_arr[i] = st;
    end
    lat_fixed = 0;
    for (int i = 0; i < 5; i++) check_eq("fill_no_stall", 32'(st_arr[i]), 32'd0);
    check_eq("full_stalls", 32'(st_arr[5] > 0), 32'd1);
    check_eq("full_not_empty", 32'(sb_empty), 32'd0);
    wait_sb_empty("full_drained");

    // RAW: load waits for the conflicting store to reach memory.
    lat_fixed = 5;
    issue(1'b1, 3'b010, 32'h130, 32'hCAFEF00D, st, ld);
    issue(1'b0, 3'b010, 32'h130, 32'h0, st, ld);
    check_eq("raw_data", ld, 32'hCAFEF00D);
    check_eq("raw_stalled", 32'(st > 5), 32'd1);
    wait_sb_empty("raw_drained");

    // Bypass: non-conflicting load is served before a still-buffered store.
    issue(1'b1, 3'b010, 32'h138, 32'h11111111, st, ld);
    issue(1'b1, 3'b010, 32'h13C, 32'h22222222, st, ld);
    issue(1'b0, 3'b010, 32'h120, 32'h0, st, ld);
    check_eq("bypass_sb_pending", 32'(sb_empty), 32'd0);
    lat_fixed = 0;
    wait_sb_empty("bypass_drained");

    // Misaligned half: pulse, no memory access.
    issue(1'b0, 3'b001, 32'h101, 32'h0, st, ld);
    @(negedge clk);
    check_eq("mis_no_cs", 32'(cs), 32'd0);

    // Reset in the middle of a load.
    lat_fixed = 50;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h10C;
    cur_ld_word = 32'h10C;
    repeat (3) @(negedge clk);
    check_eq("cs_before_reset", 32'(cs), 32'd1);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_cs", 32'(cs), 32'd0);
    check_eq("rst_mid_sb_empty", 32'(sb_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    lat_fixed = -1;
    exp_wr_q.delete();
    for (int i = 0; i < 16; i++) arch_mem[i] = slave_mem[i];

    // Randomised mix with random latency and stray mem_valid.
    spur_en = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
      end else begin
        a = 32'h100 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
        issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, st, ld);
      end
    end
    spur_en = 0;
    wait_sb_empty("final_drained");
    check_eq("final_queue", 32'(exp_wr_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) check_eq("final_mem", slave_mem[i], arch_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
